// File: rtl/comm_tx_if.sv
// Producer-side packet handshake for the comm link transmitter.
// The master drives a packet and holds it until it sees tx_ready.
interface comm_tx_if;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_addr;
    logic [15:0] tx_data;

    modport master (
        output tx_valid,
        output tx_addr,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_addr,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/comm_tx.sv
// UART transmitter for the board comm link: sends SYNC, addr, data_hi, data_lo, checksum
// as five back-to-back 8N1 bytes per accepted packet.
module comm_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic      clk,
    input  logic      reset,
    comm_tx_if.slave  bus,
    output logic      txd,
    output logic      busy
);
    localparam int unsigned       BaudW   = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0]  BaudMax = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LastByte = 3'd4;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        byte_q, byte_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        chk_q, chk_d;
    logic              txd_q, txd_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic [7:0]        cur_byte;
    logic [2:0]        bit_nxt;
    logic              baud_wrap;

    assign bus.tx_ready = ready_q;
    assign txd          = txd_q;
    assign busy         = busy_q;

    assign baud_wrap = (baud_q == BaudMax);
    assign bit_nxt   = bit_q + 3'd1;

    always_comb begin
        case (byte_q)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = addr_q;
            3'd2:    cur_byte = hi_q;
            3'd3:    cur_byte = lo_q;
            default: cur_byte = chk_q;
        endcase
    end

    // txd_d is always the value of the bit that starts on this edge, so txd stays registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        chk_d   = chk_q;
        txd_d   = txd_q;
        ready_d = ready_q;

        case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (bus.tx_valid && ready_q) begin
                    addr_d  = bus.tx_addr;
                    hi_d    = bus.tx_data[15:8];
                    lo_d    = bus.tx_data[7:0];
                    chk_d   = bus.tx_addr ^ bus.tx_data[15:8] ^ bus.tx_data[7:0];
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                    txd_d   = 1'b0;
                    ready_d = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    txd_d   = cur_byte[0];
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_nxt;
                        txd_d = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    bit_d  = 3'd0;
                    if (byte_q == LastByte) begin
                        byte_d  = 3'd0;
                        txd_d   = 1'b1;
                        ready_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        txd_d   = 1'b0;
                        state_d = StStart;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                txd_d   = 1'b1;
                ready_d = 1'b1;
                state_d = StIdle;
            end
        endcase

        busy_d = !ready_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            addr_q  <= 8'h00;
            hi_q    <= 8'h00;
            lo_q    <= 8'h00;
            chk_q   <= 8'h00;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            chk_q   <= chk_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_comm_tx.sv
// Bench for comm_tx: two instances (4 and 2 clocks per bit) checked cycle by cycle against an
// 8N1 frame model built from the packet contents, plus a mid-bit UART byte decoder.
module tb_comm_tx;
    logic clk = 1'b0;
    logic reset;
    logic txd4, busy4, txd2, busy2;
    int   checks = 0;
    int   errors = 0;
    time  last_fall4 = 0;
    time  last_fall2 = 0;

    always #5 clk = ~clk;

    comm_tx_if u_if4 ();
    comm_tx_if u_if2 ();

    comm_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if4),
        .txd   (txd4),
        .busy  (busy4)
    );

    comm_tx #(.CLKS_PER_BIT(2), .SYNC_BYTE(8'hA5)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if2),
        .txd   (txd2),
        .busy  (busy2)
    );

    always @(negedge txd4) last_fall4 = $time;
    always @(negedge txd2) last_fall2 = $time;

    function automatic logic txd_of(input int sel);
        return (sel != 0) ? txd2 : txd4;
    endfunction

    function automatic logic ready_of(input int sel);
        return (sel != 0) ? u_if2.tx_ready : u_if4.tx_ready;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel != 0) ? busy2 : busy4;
    endfunction

    // Frame contents straight from the packet: byte b lives at [8*b +: 8].
    function automatic logic [39:0] model_bytes(input logic [7:0] a, input logic [15:0] d);
        logic [7:0] chk;
        chk = a ^ d[15:8] ^ d[7:0];
        return {chk, d[7:0], d[15:8], a, 8'hA5};
    endfunction

    // Line level for each of the 50 bit slots of a frame.
    function automatic logic [49:0] model_bits(input logic [39:0] bytes);
        logic [49:0] bits;
        for (int n = 0; n < 50; n++) begin
            if (n % 10 == 0) bits[n] = 1'b0;
            else if (n % 10 == 9) bits[n] = 1'b1;
            else bits[n] = bytes[8 * (n / 10) + (n % 10) - 1];
        end
        return bits;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] a, input logic [15:0] d);
        if (sel != 0) begin
            u_if2.tx_valid = v;
            u_if2.tx_addr  = a;
            u_if2.tx_data  = d;
        end else begin
            u_if4.tx_valid = v;
            u_if4.tx_addr  = a;
            u_if4.tx_data  = d;
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        checks++;
        if (txd_of(sel) !== 1'b1 || ready_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0) begin
            errors++;
            $display("FAIL %s dut%0d: txd/ready/busy = %b%b%b, required 110", tag, sel,
                     txd_of(sel), ready_of(sel), busy_of(sel));
        end
    endtask

    // Called at a negedge with the DUT idle. mode 0: drop valid after acceptance;
    // mode 1: scramble the bus every cycle during the frame; mode 2: keep valid high
    // and present (na, nd) as the next packet.
    task automatic run_frame(input int sel, input logic [7:0] a, input logic [15:0] d,
                             input int mode, input logic [7:0] na, input logic [15:0] nd,
                             output logic [39:0] dec, output time start_fall);
        int          c;
        int          n;
        int          p;
        logic [39:0] exp_bytes;
        logic [49:0] exp_bits;
        c         = (sel != 0) ? 2 : 4;
        exp_bytes = model_bytes(a, d);
        exp_bits  = model_bits(exp_bytes);
        dec       = '0;
        check_idle(sel, "pre_accept");
        drive(sel, 1'b1, a, d);
        @(posedge clk);
        @(negedge clk);
        start_fall = (sel != 0) ? last_fall2 : last_fall4;
        for (int j = 0; j < 50 * c; j++) begin
            checks++;
            if (txd_of(sel) !== exp_bits[j / c] || ready_of(sel) !== 1'b0 ||
                busy_of(sel) !== 1'b1) begin
                errors++;
                $display("FAIL frame_cycle dut%0d j=%0d: txd/ready/busy = %b%b%b, required %b01",
                         sel, j, txd_of(sel), ready_of(sel), busy_of(sel), exp_bits[j / c]);
            end
            if ((j % c) == (c / 2)) begin
                n = j / c;
                p = n % 10;
                if (p >= 1 && p <= 8) dec[8 * (n / 10) + p - 1] = txd_of(sel);
            end
            if (mode == 1) drive(sel, 1'($urandom_range(1)), 8'($urandom), 16'($urandom));
            else if (j == 0 && mode == 2) drive(sel, 1'b1, na, nd);
            else if (j == 0) drive(sel, 1'b0, 8'h00, 16'h0000);
            @(negedge clk);
        end
        check_idle(sel, "frame_end");
        if (mode == 1) drive(sel, 1'b0, 8'h00, 16'h0000);
        for (int b = 0; b < 5; b++) begin
            checks++;
            if (dec[8 * b +: 8] !== exp_bytes[8 * b +: 8]) begin
                errors++;
                $display("FAIL uart_byte dut%0d byte%0d: decoded %h, required %h", sel, b,
                         dec[8 * b +: 8], exp_bytes[8 * b +: 8]);
            end
        end
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 8'h00, 16'h0000);
        drive(1, 1'b0, 8'h00, 16'h0000);
        reset = 1'b1;
        #1;
        check_idle(0, "reset_state");
        check_idle(1, "reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_idle(0, "idle_after_reset");
        end
    endtask

    task automatic test_single();
        logic [39:0] dec;
        time         t;
        run_frame(0, 8'h12, 16'h3456, 0, 8'h00, 16'h0000, dec, t);
        checks++;
        if (dec[39:32] !== 8'h70) begin
            errors++;
            $display("FAIL single_chk: got %h, required 70", dec[39:32]);
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] dec;
        time         t1, t2;
        run_frame(0, 8'h01, 16'h0000, 2, 8'hFF, 16'hFFFF, dec, t1);
        run_frame(0, 8'hFF, 16'hFFFF, 0, 8'h00, 16'h0000, dec, t2);
        checks++;
        if ((t2 - t1) != 201 * 10) begin
            errors++;
            $display("FAIL b2b_start_gap: %0t, required %0t", t2 - t1, 201 * 10);
        end
        checks++;
        if (dec[39:32] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_chk: got %h, required ff", dec[39:32]);
        end
    endtask

    task automatic test_held_change();
        logic [39:0] dec;
        time         t;
        run_frame(0, 8'h3C, 16'hC3A1, 1, 8'h00, 16'h0000, dec, t);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle(0, "no_extra_frame");
        end
    endtask

    task automatic test_reset_mid();
        logic [39:0] dec;
        time         t;
        logic [7:0]  a;
        logic [15:0] d;
        check_idle(0, "pre_reset_mid");
        drive(0, 1'b1, 8'h5A, 16'h00FF);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 16'h0000);
        // 90 cycles in: bit slot 22, bit 1 of data_hi (0x00), so the line is low.
        repeat (90) @(negedge clk);
        checks++;
        if (txd4 !== 1'b0 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_line: txd/busy = %b%b, required 01", txd4, busy4);
        end
        #2;
        reset = 1'b1;
        #1;
        check_idle(0, "async_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle(0, "after_reset_release");
        a = 8'($urandom);
        d = 16'($urandom);
        run_frame(0, a, d, 0, 8'h00, 16'h0000, dec, t);
    endtask

    task automatic test_boundary();
        logic [39:0] dec;
        time         t;
        run_frame(1, 8'hAA, 16'h55AA, 0, 8'h00, 16'h0000, dec, t);
        checks++;
        if (dec[39:32] !== 8'h55) begin
            errors++;
            $display("FAIL boundary_chk: got %h, required 55", dec[39:32]);
        end
    endtask

    task automatic test_random();
        logic [39:0] dec;
        time         t;
        int          sel;
        int          gap;
        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(1));
            gap = int'($urandom_range(3));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check_idle(sel, "random_gap");
            end
            run_frame(sel, 8'($urandom), 16'($urandom), 0, 8'h00, 16'h0000, dec, t);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_held_change();
        test_reset_mid();
        test_boundary();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
